// File: rtl/icache_linefill_responder_if.sv
// Bundle of the line-fill responder's request, memory and return signals.
// The slave modport is the responder's view; master is the surrounding system.
interface icache_linefill_responder_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TXNID_WIDTH    = 5,
  parameter int ENTRY_ID_WIDTH = 3,
  parameter int BEAT_WIDTH     = 64,
  parameter int BEATS          = 4
);
  logic                          txreq_vld;
  logic                          txreq_rdy;
  logic [ADDR_WIDTH-1:0]         txreq_addr;
  logic [TXNID_WIDTH-1:0]        txreq_txnid;
  logic [ENTRY_ID_WIDTH-1:0]     txreq_entry_id;
  logic                          mem_req_vld;
  logic                          mem_req_rdy;
  logic [ADDR_WIDTH-1:0]         mem_req_addr;
  logic                          mem_rsp_vld;
  logic [BEAT_WIDTH-1:0]         mem_rsp_data;
  logic                          linefill_done;
  logic [ENTRY_ID_WIDTH-1:0]     linefill_entry_idx;
  logic [TXNID_WIDTH-1:0]        linefill_txnid;
  logic [BEATS*BEAT_WIDTH-1:0]   linefill_data;
  logic                          busy;
  logic                          err_unexp_rsp;

  modport slave (
    input  txreq_vld, txreq_addr, txreq_txnid, txreq_entry_id,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    output txreq_rdy, mem_req_vld, mem_req_addr,
    output linefill_done, linefill_entry_idx, linefill_txnid, linefill_data,
    output busy, err_unexp_rsp
  );

  modport master (
    output txreq_vld, txreq_addr, txreq_txnid, txreq_entry_id,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    input  txreq_rdy, mem_req_vld, mem_req_addr,
    input  linefill_done, linefill_entry_idx, linefill_txnid, linefill_data,
    input  busy, err_unexp_rsp
  );
endinterface

// File: rtl/icache_linefill_responder.sv
// Downstream end of the icache MSHR miss path: queues line-fill requests in
// order, issues one line-aligned memory read per request, assembles the beats
// into a full line and returns it with a one-cycle done pulse.
module icache_linefill_responder #(
  parameter int DEPTH          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int TXNID_WIDTH    = 5,
  parameter int ENTRY_ID_WIDTH = 3,
  parameter int BEAT_WIDTH     = 64,
  parameter int BEATS          = 4
) (
  input  logic clk,
  input  logic rst,
  icache_linefill_responder_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BCNT_W = $clog2(BEATS);
  localparam int LINE_W = BEATS * BEAT_WIDTH;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t                    state, state_nxt;

  // Only the line-address bits are kept; the byte offset is always zeroed
  // on the memory request anyway.
  logic [TAG_W-1:0]          q_tag   [DEPTH];
  logic [TXNID_WIDTH-1:0]    q_txnid [DEPTH];
  logic [ENTRY_ID_WIDTH-1:0] q_entry [DEPTH];

  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [BCNT_W-1:0]         beat_cnt;
  logic [LINE_W-1:0]         line_buf;
  logic                      err_q;

  logic                      rdy;
  logic                      push, pop, req_acc, beat_take, last_beat;

  // Full blocks a push even in a pop cycle, so a freed slot is reused only
  // from the following cycle.
  assign rdy       = (count != CNT_W'(DEPTH));
  assign push      = bus.txreq_vld && rdy;
  assign pop       = (state == DONE);
  assign req_acc   = (state == REQ) && bus.mem_req_rdy;
  assign beat_take = (state == DATA) && bus.mem_rsp_vld;
  assign last_beat = beat_take && (beat_cnt == BCNT_W'(BEATS - 1));

  // Queue payload storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_tag[wr_ptr]   <= bus.txreq_addr[ADDR_WIDTH-1:OFF_W];
      q_txnid[wr_ptr] <= bus.txreq_txnid;
      q_entry[wr_ptr] <= bus.txreq_entry_id;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. IDLE also looks at the incoming push so a request
  // landing in an empty queue is presented to memory on the very next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (count != '0 || push) state_nxt = REQ;
      REQ:  if (bus.mem_req_rdy)     state_nxt = DATA;
      DATA: if (last_beat)           state_nxt = DONE;
      DONE: state_nxt = (count > CNT_W'(1)) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter and line assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      line_buf <= '0;
    end else begin
      if (req_acc)        beat_cnt <= '0;
      else if (beat_take) beat_cnt <= beat_cnt + BCNT_W'(1);
      if (beat_take) line_buf[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rsp_data;
    end
  end

  // Sticky flag for beats arriving while no read is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_q <= 1'b0;
    else if (bus.mem_rsp_vld && state != DATA) err_q <= 1'b1;
  end

  assign bus.txreq_rdy          = rdy;
  assign bus.mem_req_vld        = (state == REQ);
  assign bus.mem_req_addr       = (state == REQ) ? {q_tag[rd_ptr], {OFF_W{1'b0}}} : '0;
  assign bus.linefill_done      = pop;
  assign bus.linefill_entry_idx = pop ? q_entry[rd_ptr] : '0;
  assign bus.linefill_txnid     = pop ? q_txnid[rd_ptr] : '0;
  assign bus.linefill_data      = line_buf;
  assign bus.busy               = (count != '0) || (state != IDLE);
  assign bus.err_unexp_rsp      = err_q;

endmodule

// File: tb/tb_icache_linefill_responder.sv
// Randomized bench for icache_linefill_responder: an in-order reference model
// (queue of accepted requests + lines handed out by the memory side) is
// compared against every observed linefill return.
module tb_icache_linefill_responder;
  localparam int DEPTH          = 4;
  localparam int ADDR_WIDTH     = 32;
  localparam int TXNID_WIDTH    = 5;
  localparam int ENTRY_ID_WIDTH = 3;
  localparam int BEAT_WIDTH     = 64;
  localparam int BEATS          = 4;
  localparam int LINE_W         = BEATS * BEAT_WIDTH;
  localparam int LINE_BYTES     = LINE_W / 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  txnid;
    logic [2:0]  entry;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  req_t              exp_req[$];
  logic [LINE_W-1:0] exp_line[$];
  req_t              obs_req[$];
  logic [LINE_W-1:0] obs_line[$];
  int                obs_cyc[$];
  int                srv_idx = 0;
  int                gap_tab[BEATS];
  logic [63:0]       fixed_base = '0;
  int                last_beat_cyc = 0;
  int                accept_cyc = 0;
  req_t              mon_r;

  icache_linefill_responder_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .TXNID_WIDTH(TXNID_WIDTH), .ENTRY_ID_WIDTH(ENTRY_ID_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH), .BEATS(BEATS)
  ) bus ();

  icache_linefill_responder #(
    .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .TXNID_WIDTH(TXNID_WIDTH),
    .ENTRY_ID_WIDTH(ENTRY_ID_WIDTH), .BEAT_WIDTH(BEAT_WIDTH), .BEATS(BEATS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.linefill_done === 1'b1) begin
      mon_r.addr  = '0;
      mon_r.txnid = bus.linefill_txnid;
      mon_r.entry = bus.linefill_entry_idx;
      obs_req.push_back(mon_r);
      obs_line.push_back(bus.linefill_data);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic push_req(input logic [31:0] a, input logic [4:0] t, input logic [2:0] e);
    req_t r;
    bit   ok;
    ok = 1'b0;
    @(negedge clk);
    bus.txreq_vld = 1'b1; bus.txreq_addr = a; bus.txreq_txnid = t; bus.txreq_entry_id = e;
    for (int n = 0; n < 300 && !ok; n++) begin
      ok = bus.txreq_rdy;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1 bus.txreq_vld = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_accept: txreq_rdy got 0 for 300 cycles, want 1");
    end else begin
      r.addr = a; r.txnid = t; r.entry = e;
      exp_req.push_back(r);
      accept_cyc = cyc;
    end
  endtask

  task automatic serve_line(input int req_stall, input bit rand_gaps);
    logic [LINE_W-1:0] line;
    logic [31:0]       exp_addr;
    logic [63:0]       d;
    bit                seen;
    int                g;
    seen = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 500 && !seen; n++) begin
      if (bus.mem_req_vld === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL mem_req_wait: mem_req_vld got 0 for 500 cycles, want 1");
      return;
    end
    if (srv_idx < exp_req.size())
      exp_addr = exp_req[srv_idx].addr - (exp_req[srv_idx].addr % LINE_BYTES);
    else
      exp_addr = '1;
    for (int s = 0; s <= req_stall; s++) begin
      n_cmp++;
      if (bus.mem_req_vld !== 1'b1 || bus.mem_req_addr !== exp_addr) begin
        n_err++;
        $display("FAIL mem_req_addr: got vld=%0b addr=%h, want vld=1 addr=%h",
                 bus.mem_req_vld, bus.mem_req_addr, exp_addr);
      end
      if (s < req_stall) @(negedge clk);
    end
    bus.mem_req_rdy = 1'b1;
    @(posedge clk);
    #1 bus.mem_req_rdy = 1'b0;
    line = '0;
    for (int k = 0; k < BEATS; k++) begin
      g = rand_gaps ? int'($urandom_range(0, 2)) : gap_tab[k];
      @(negedge clk);
      repeat (g) @(negedge clk);
      d = (fixed_base != '0) ? fixed_base + 64'(k) : {$urandom, $urandom};
      bus.mem_rsp_vld = 1'b1; bus.mem_rsp_data = d;
      line[k*BEAT_WIDTH +: BEAT_WIDTH] = d;
      @(posedge clk);
      #1 bus.mem_rsp_vld = 1'b0;
    end
    last_beat_cyc = cyc;
    exp_line.push_back(line);
    srv_idx++;
  endtask

  task automatic check_returns(input int n);
    for (int w = 0; w < 300 && obs_req.size() < n; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_req.size() != n) begin
      n_err++;
      $display("FAIL return_count: got %0d linefill_done pulses, want %0d", obs_req.size(), n);
    end
    for (int i = 0; i < n && i < obs_req.size() && i < exp_req.size() && i < exp_line.size(); i++) begin
      n_cmp++;
      if (obs_req[i].entry !== exp_req[i].entry || obs_req[i].txnid !== exp_req[i].txnid ||
          obs_line[i] !== exp_line[i]) begin
        n_err++;
        $display("FAIL return[%0d]: got entry=%0d txnid=%0d data=%h, want entry=%0d txnid=%0d data=%h",
                 i, obs_req[i].entry, obs_req[i].txnid, obs_line[i],
                 exp_req[i].entry, exp_req[i].txnid, exp_line[i]);
      end
    end
    exp_req.delete(); exp_line.delete();
    obs_req.delete(); obs_line.delete(); obs_cyc.delete();
    srv_idx = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.txreq_rdy !== 1'b1 || bus.mem_req_vld !== 1'b0 || bus.mem_req_addr !== '0 ||
        bus.linefill_done !== 1'b0 || bus.linefill_entry_idx !== '0 || bus.linefill_txnid !== '0 ||
        bus.linefill_data !== '0 || bus.busy !== 1'b0 || bus.err_unexp_rsp !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%0b mreq=%0b addr=%h done=%0b idx=%0d txn=%0d busy=%0b err=%0b, want rdy=1 rest 0",
               bus.txreq_rdy, bus.mem_req_vld, bus.mem_req_addr, bus.linefill_done,
               bus.linefill_entry_idx, bus.linefill_txnid, bus.busy, bus.err_unexp_rsp);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.txreq_rdy !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req_vld !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got rdy=%0b busy=%0b mreq=%0b, want 1 0 0",
               bus.txreq_rdy, bus.busy, bus.mem_req_vld);
    end
  endtask

  task automatic test_single_fill();
    logic [LINE_W-1:0] want;
    want = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    fixed_base = 64'hA0;
    gap_tab = '{0, 0, 0, 0};
    push_req(32'h0000_1234, 5'd5, 3'd2);
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req_vld !== 1'b1 || bus.mem_req_addr !== 32'h0000_1220) begin
      n_err++;
      $display("FAIL single_req_timing: got vld=%0b addr=%h one cycle after accept, want vld=1 addr=00001220",
               bus.mem_req_vld, bus.mem_req_addr);
    end
    serve_line(0, 1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (obs_cyc.size() != 1 || obs_cyc[0] != last_beat_cyc || obs_line[0] !== want) begin
      n_err++;
      $display("FAIL single_done: got %0d pulses first_cyc=%0d, want 1 pulse at cyc %0d with data %h",
               obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, last_beat_cyc, want);
    end
    fixed_base = '0;
    check_returns(1);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy: got busy=%0b after return, want 0", bus.busy);
    end
  endtask

  task automatic test_queue_full();
    int first_done;
    for (int i = 0; i < 4; i++) push_req($urandom, 5'($urandom), 3'(i));
    @(negedge clk);
    n_cmp++;
    if (bus.txreq_rdy !== 1'b0 || bus.mem_req_vld !== 1'b1) begin
      n_err++;
      $display("FAIL full_rdy: got rdy=%0b mreq=%0b with 4 queued, want rdy=0 mreq=1",
               bus.txreq_rdy, bus.mem_req_vld);
    end
    fork
      push_req($urandom, 5'($urandom), 3'd4);
      repeat (5) serve_line(0, 1'b1);
    join
    @(negedge clk); #1;
    first_done = (obs_cyc.size() > 0) ? obs_cyc[0] : -100;
    n_cmp++;
    if (accept_cyc != first_done + 2) begin
      n_err++;
      $display("FAIL full_5th_accept: got accept at cyc %0d, want %0d (cycle after first done)",
               accept_cyc, first_done + 2);
    end
    check_returns(5);
  endtask

  task automatic test_mem_stalls();
    gap_tab = '{0, 0, 2, 1};
    push_req($urandom, 5'($urandom), 3'($urandom));
    serve_line(3, 1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (obs_cyc.size() != 1 || obs_cyc[0] != last_beat_cyc) begin
      n_err++;
      $display("FAIL stall_done_timing: got %0d pulses first_cyc=%0d, want 1 at cyc %0d",
               obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, last_beat_cyc);
    end
    check_returns(1);
  endtask

  task automatic test_unexp_beat();
    n_cmp++;
    if (bus.err_unexp_rsp !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL unexp_pre: got err=%0b busy=%0b, want 0 0", bus.err_unexp_rsp, bus.busy);
    end
    @(negedge clk);
    bus.mem_rsp_vld = 1'b1; bus.mem_rsp_data = {$urandom, $urandom};
    @(posedge clk);
    #1 bus.mem_rsp_vld = 1'b0;
    n_cmp++;
    if (bus.err_unexp_rsp !== 1'b1) begin
      n_err++;
      $display("FAIL unexp_set: got err=%0b, want 1", bus.err_unexp_rsp);
    end
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.err_unexp_rsp !== 1'b1 || obs_req.size() != 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL unexp_hold: got err=%0b pulses=%0d busy=%0b, want 1 0 0",
               bus.err_unexp_rsp, obs_req.size(), bus.busy);
    end
    push_req($urandom, 5'($urandom), 3'($urandom));
    serve_line(1, 1'b1);
    check_returns(1);
    n_cmp++;
    if (bus.err_unexp_rsp !== 1'b1) begin
      n_err++;
      $display("FAIL unexp_sticky: got err=%0b after normal fill, want 1", bus.err_unexp_rsp);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    push_req($urandom, 5'($urandom), 3'd6);
    push_req($urandom, 5'($urandom), 3'd7);
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = (bus.mem_req_vld === 1'b1);
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rstmid_req: mem_req_vld got 0 for 50 cycles, want 1");
    end
    bus.mem_req_rdy = 1'b1;
    @(posedge clk);
    #1 bus.mem_req_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.mem_rsp_vld = 1'b1; bus.mem_rsp_data = {$urandom, $urandom};
      @(posedge clk);
      #1 bus.mem_rsp_vld = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.txreq_rdy !== 1'b1 || bus.mem_req_vld !== 1'b0 || bus.mem_req_addr !== '0 ||
        bus.linefill_done !== 1'b0 || bus.linefill_entry_idx !== '0 || bus.linefill_txnid !== '0 ||
        bus.linefill_data !== '0 || bus.busy !== 1'b0 || bus.err_unexp_rsp !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_values: got rdy=%0b mreq=%0b done=%0b busy=%0b err=%0b data=%h, want rdy=1 rest 0",
               bus.txreq_rdy, bus.mem_req_vld, bus.linefill_done, bus.busy, bus.err_unexp_rsp,
               bus.linefill_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_req.size() != 0 || bus.mem_req_vld !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_quiet: got pulses=%0d mreq=%0b busy=%0b after reset, want 0 0 0",
               obs_req.size(), bus.mem_req_vld, bus.busy);
    end
    exp_req.delete(); exp_line.delete(); srv_idx = 0;
    push_req($urandom, 5'($urandom), 3'($urandom));
    serve_line(0, 1'b1);
    check_returns(1);
  endtask

  task automatic test_pointer_wrap();
    gap_tab = '{0, 0, 0, 0};
    fork
      for (int i = 0; i < 10; i++) push_req($urandom, 5'($urandom), 3'(i % 8));
      repeat (10) serve_line(0, 1'b0);
    join
    repeat (2) @(negedge clk);
    #1;
    for (int i = 1; i < 10 && i < obs_cyc.size(); i++) begin
      n_cmp++;
      if (obs_cyc[i] - obs_cyc[i-1] != BEATS + 2) begin
        n_err++;
        $display("FAIL wrap_spacing[%0d]: got %0d cycles between returns, want %0d",
                 i, obs_cyc[i] - obs_cyc[i-1], BEATS + 2);
      end
    end
    check_returns(10);
  endtask

  initial begin
    rst = 1'b1;
    bus.txreq_vld = 1'b0; bus.txreq_addr = '0; bus.txreq_txnid = '0; bus.txreq_entry_id = '0;
    bus.mem_req_rdy = 1'b0; bus.mem_rsp_vld = 1'b0; bus.mem_rsp_data = '0;
    test_reset();
    test_single_fill();
    test_queue_full();
    test_mem_stalls();
    test_unexp_beat();
    test_reset_mid();
    test_pointer_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
